// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round constants, initial hash, round functions and core state type.
package sha256_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, NEXT} state_e;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [7:0][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction
  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction
  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction
  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
endpackage

// File: rtl/sha256_w_mem.sv
// sha256_w_mem: 16-word sliding message schedule window; w_t is the current round word.
module sha256_w_mem
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         next,
  input  logic [511:0] block,
  output logic [31:0]  w_t
);
  logic [15:0][31:0] blk;
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  assign blk = block;
  assign w_t = w_q[0];
  always_comb begin
    w_d = w_q;
    if (load) begin
      for (int i = 0; i < 16; i++) w_d[i] = blk[15-i];
    end else if (next) begin
      for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
      w_d[15] = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    end
  end
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      w_q <= w_d;
    end
  end
endmodule

// File: rtl/sha256_core.sv
// sha256_core: iterative SHA-256 compression, one round per clock, chained multi-block digests.
module sha256_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         last_block,
  input  logic [511:0] block,
  output logic         done,
  output logic         digest_update,
  output logic [255:0] digest
);
  state_e state_q, state_d;
  logic [5:0] t_q, t_d;
  logic [7:0][31:0] wv_q, wv_d, h_q, h_d;
  logic done_q, done_d, update_q, update_d;
  logic [31:0] w_t, t1, t2;
  sha256_w_mem u_w_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .load    ((state_q == IDLE && start) || state_q == NEXT),
    .next    (state_q == ROUND),
    .block   (block),
    .w_t     (w_t)
  );
  assign t1 = wv_q[0] + big_sigma1(wv_q[3]) + ch(wv_q[3], wv_q[2], wv_q[1]) + K[t_q] + w_t;
  assign t2 = big_sigma0(wv_q[7]) + maj(wv_q[7], wv_q[6], wv_q[5]);
  assign digest = h_q;
  assign done = done_q;
  assign digest_update = update_q;
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    wv_d = wv_q;
    h_d = h_q;
    done_d = done_q;
    update_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        h_d = IV;
        wv_d = IV;
        t_d = '0;
        done_d = 1'b0;
        state_d = ROUND;
      end
      ROUND: begin
        wv_d = {t1 + t2, wv_q[7:5], wv_q[4] + t1, wv_q[3:1]};
        t_d = t_q + 6'd1;
        state_d = t_q == 6'd63 ? FINAL : ROUND;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
        done_d = last_block;
        update_d = !last_block;
        state_d = last_block ? IDLE : NEXT;
      end
      NEXT: begin
        wv_d = h_q;
        t_d = '0;
        state_d = ROUND;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= IDLE;
      t_q <= '0;
      wv_q <= '0;
      h_q <= '0;
      done_q <= 1'b0;
      update_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      wv_q <= wv_d;
      h_q <= h_d;
      done_q <= done_d;
      update_q <= update_d;
    end
  end
endmodule

// File: tb/tb_sha256_core.sv
// tb_sha256_core: directed known-answer and chained-block checks for sha256_core.
module tb_sha256_core;
  import sha256_pkg::*;
  logic clk = 1'b0;
  logic reset_n, start, last_block, done, digest_update;
  logic [511:0] block;
  logic [255:0] digest;
  logic [511:0] blks [4];
  int errs = 0;
  int checks = 0;
  localparam logic [255:0] ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2  = {448'h0, 64'h1c0};
  always #5 clk = ~clk;
  sha256_core dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .last_block    (last_block),
    .block         (block),
    .done          (done),
    .digest_update (digest_update),
    .digest        (digest)
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] model(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] hh [8];
    logic [31:0] s0, s1, x1, x2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      hh[i] = hin[255-32*i -: 32];
      v[i] = hh[i];
    end
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      x1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
      s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      x2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hh[i] + v[i];
    return r;
  endfunction
  task automatic run(input int n, input int mid, input logic [255:0] exp, input string tag);
    int cyc;
    int ups;
    logic [255:0] held;
    ups = 0;
    @(negedge clk);
    block = blks[0];
    last_block = (n == 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_drop"}, 256'(done), 256'(0));
    for (int b = 0; b < n; b++) begin
      cyc = 0;
      while (!done && !digest_update && cyc < 200) begin
        start = (cyc == mid);
        @(negedge clk);
        cyc++;
      end
      start = 1'b0;
      check($sformatf("%s_lat%0d", tag, b), 256'(cyc), 256'(65));
      check($sformatf("%s_excl%0d", tag, b), 256'(done && digest_update), 256'(0));
      if (digest_update) begin
        ups++;
        block = blks[(b + 1) % 4];
        last_block = (b + 2 == n);
        @(negedge clk);
        check($sformatf("%s_pulse%0d", tag, b), 256'(digest_update), 256'(0));
      end
    end
    check({tag, "_updates"}, 256'(ups), 256'(n - 1));
    check({tag, "_done"}, 256'(done), 256'(1));
    check({tag, "_digest"}, digest, exp);
    held = digest;
    repeat (3) @(negedge clk);
    check({tag, "_hold"}, {digest ^ held, 255'(0)} | 256'(done), 256'(1));
  endtask
  initial begin
    logic [255:0] exp4;
    logic [511:0] rb;
    reset_n = 1'b1;
    start = 1'b0;
    last_block = 1'b0;
    block = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 256'(done), 256'(0));
    check("rst_update", 256'(digest_update), 256'(0));
    check("rst_digest", digest, 256'(0));
    reset_n = 1'b0;
    blks[0] = ABC_BLK;
    run(1, -1, ABC, "abc");
    blks[0] = EMPTY_BLK;
    run(1, -1, EMPTY, "empty");
    blks[0] = TWO_BLK1;
    blks[1] = TWO_BLK2;
    run(2, -1, TWO, "two");
    exp4 = IV;
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < 16; j++) rb[511-32*j -: 32] = $urandom;
      blks[b] = rb;
      exp4 = model(exp4, rb);
    end
    run(3, -1, exp4, "three");
    blks[0] = ABC_BLK;
    run(1, 20, ABC, "abc_mid");
    @(negedge clk);
    block = ABC_BLK;
    last_block = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    check("midrst_done", 256'(done), 256'(0));
    check("midrst_update", 256'(digest_update), 256'(0));
    check("midrst_digest", digest, 256'(0));
    repeat (70) @(negedge clk);
    check("midrst_idle", {digest, 255'(0)} | 256'(done || digest_update), 256'(0));
    run(1, -1, ABC, "abc_after_rst");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
